rv32im_decode_stage: RTL and testbench

//  ID stage; sits directly downstream of the fetch stage and consumes IF_ID_IR, PC and the TAKEN_BRANCH prediction.

---
 rtl/rv32im_decode_stage.sv | 201 ++++++++++++++++++++
 tb/tb_rv32im_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_decode_stage.sv
// RV32IM decode stage: register file, immediate generation, instruction classification and the ID/EX register.
// Load-use and busy-execute stalls are signalled back to fetch through HALTED.
module rv32im_decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            RESET,
   input  logic [31:0]     IF_ID_IR,
   input  logic [XLEN-1:0] IF_ID_PC,
   input  logic            if_valid,
   input  logic            pred_taken,
   input  logic            flush,
   input  logic            ex_busy,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            HALTED,
   output logic            ID_EX_valid,
   output logic [XLEN-1:0] ID_EX_PC,
   output logic [XLEN-1:0] ID_EX_rs1_val,
   output logic [XLEN-1:0] ID_EX_rs2_val,
   output logic [XLEN-1:0] ID_EX_imm,
   output logic [4:0]      ID_EX_rs1,
   output logic [4:0]      ID_EX_rs2,
   output logic [4:0]      ID_EX_rd,
   output logic [6:0]      ID_EX_opcode,
   output logic [2:0]      ID_EX_funct3,
   output logic [6:0]      ID_EX_funct7,
   output logic [6:0]      ID_EX_ctrl,
   output logic            ID_EX_pred
);

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_JALR   = 7'b1100111,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_REG    = 7'b0110011
   } opcode_e;

   typedef struct packed {
      logic rd_we;
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_jump;
      logic is_muldiv;
      logic illegal;
   } ctrl_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      ctrl_t           ctrl;
      logic            pred;
   } idex_t;

   logic [XLEN-1:0] rf_q [NREGS];
   idex_t           idex_q, idex_d, dec;

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] imm, rs1_val, rs2_val;
   ctrl_t           ctrl;
   logic            rs1_used, rs2_used, load_use;

   assign opcode = IF_ID_IR[6:0];
   assign rd     = IF_ID_IR[11:7];
   assign rs1    = IF_ID_IR[19:15];
   assign rs2    = IF_ID_IR[24:20];

   // NOTE: the register file is cleared by reset because software relies on x1..x31 reading zero;
   // that rules out a RAM macro, so the array lives in flops.
   always_ff @(posedge clk) begin
      if (RESET) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_en && wb_rd != '0) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      imm      = '0;
      ctrl     = '0;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opcode)
         OP_LOAD: begin
            imm          = XLEN'($signed(IF_ID_IR[31:20]));
            ctrl.is_load = 1'b1;
         end
         OP_IMM:  imm = XLEN'($signed(IF_ID_IR[31:20]));
         OP_JALR: begin
            imm          = XLEN'($signed(IF_ID_IR[31:20]));
            ctrl.is_jump = 1'b1;
         end
         OP_STORE: begin
            imm           = XLEN'($signed({IF_ID_IR[31:25], IF_ID_IR[11:7]}));
            ctrl.is_store = 1'b1;
            rs2_used      = 1'b1;
         end
         OP_BRANCH: begin
            imm            = XLEN'($signed({IF_ID_IR[31], IF_ID_IR[7], IF_ID_IR[30:25], IF_ID_IR[11:8], 1'b0}));
            ctrl.is_branch = 1'b1;
            rs2_used       = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm      = XLEN'($signed({IF_ID_IR[31:12], 12'b0}));
            rs1_used = 1'b0;
         end
         OP_JAL: begin
            imm          = XLEN'($signed({IF_ID_IR[31], IF_ID_IR[19:12], IF_ID_IR[20], IF_ID_IR[30:21], 1'b0}));
            ctrl.is_jump = 1'b1;
            rs1_used     = 1'b0;
         end
         OP_REG: begin
            ctrl.is_muldiv = (IF_ID_IR[31:25] == 7'b0000001);
            rs2_used       = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
      ctrl.rd_we = !ctrl.is_store && !ctrl.is_branch && !ctrl.illegal && (rd != '0);
   end

   // Write-first bypass lets an instruction see the value being written back in the same cycle.
   always_comb begin
      if (rs1 == '0)                    rs1_val = '0;
      else if (wb_en && wb_rd == rs1)   rs1_val = wb_data;
      else                              rs1_val = rf_q[rs1];
      if (rs2 == '0)                    rs2_val = '0;
      else if (wb_en && wb_rd == rs2)   rs2_val = wb_data;
      else                              rs2_val = rf_q[rs2];
   end

   always_comb begin
      dec = '{valid:   1'b1,
              pc:      IF_ID_PC,
              rs1_val: rs1_val,
              rs2_val: rs2_val,
              imm:     imm,
              rs1:     rs1,
              rs2:     rs2,
              rd:      rd,
              opcode:  opcode,
              funct3:  IF_ID_IR[14:12],
              funct7:  IF_ID_IR[31:25],
              ctrl:    ctrl,
              pred:    pred_taken};
   end

   assign load_use = idex_q.valid && idex_q.ctrl.is_load && (idex_q.rd != '0) && if_valid &&
                     ((rs1_used && rs1 == idex_q.rd) || (rs2_used && rs2 == idex_q.rd));

   assign HALTED = !RESET && !flush && (ex_busy || load_use);

   // Bubbles only drop valid; the datapath fields keep their last values.
   always_comb begin
      idex_d = idex_q;
      if (flush)          idex_d.valid = 1'b0;
      else if (ex_busy)   idex_d = idex_q;
      else if (load_use)  idex_d.valid = 1'b0;
      else if (if_valid)  idex_d = dec;
      else                idex_d.valid = 1'b0;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (RESET) idex_q <= '0;
      else       idex_q <= idex_d;
   end

   assign ID_EX_valid   = idex_q.valid;
   assign ID_EX_PC      = idex_q.pc;
   assign ID_EX_rs1_val = idex_q.rs1_val;
   assign ID_EX_rs2_val = idex_q.rs2_val;
   assign ID_EX_imm     = idex_q.imm;
   assign ID_EX_rs1     = idex_q.rs1;
   assign ID_EX_rs2     = idex_q.rs2;
   assign ID_EX_rd      = idex_q.rd;
   assign ID_EX_opcode  = idex_q.opcode;
   assign ID_EX_funct3  = idex_q.funct3;
   assign ID_EX_funct7  = idex_q.funct7;
   assign ID_EX_ctrl    = idex_q.ctrl;
   assign ID_EX_pred    = idex_q.pred;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// Scoreboard bench for rv32im_decode_stage: the stimulus pushes model predictions into a queue,
// and an independent monitor pops and compares them against the DUT every cycle.
module tb_rv32im_decode_stage;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] IF_ID_IR = '0, IF_ID_PC = '0, wb_data = '0;
   logic        if_valid = 1'b0, pred_taken = 1'b0, flush = 1'b0, ex_busy = 1'b0, wb_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        HALTED, ID_EX_valid, ID_EX_pred;
   logic [31:0] ID_EX_PC, ID_EX_rs1_val, ID_EX_rs2_val, ID_EX_imm;
   logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
   logic [6:0]  ID_EX_opcode, ID_EX_funct7, ID_EX_ctrl;
   logic [2:0]  ID_EX_funct3;

   always #5 clk = ~clk;

   rv32im_decode_stage dut (
      .clk(clk), .RESET(RESET), .IF_ID_IR(IF_ID_IR), .IF_ID_PC(IF_ID_PC),
      .if_valid(if_valid), .pred_taken(pred_taken), .flush(flush), .ex_busy(ex_busy),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .HALTED(HALTED),
      .ID_EX_valid(ID_EX_valid), .ID_EX_PC(ID_EX_PC), .ID_EX_rs1_val(ID_EX_rs1_val),
      .ID_EX_rs2_val(ID_EX_rs2_val), .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1),
      .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd), .ID_EX_opcode(ID_EX_opcode),
      .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7(ID_EX_funct7), .ID_EX_ctrl(ID_EX_ctrl),
      .ID_EX_pred(ID_EX_pred)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1v, rs2v, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7, ctrl;
      logic        pred;
   } st_t;

   typedef struct packed {
      logic halted;
      st_t  st;
   } exp_t;

   exp_t        sb_q [$];
   st_t         m_st;
   logic [31:0] m_rf [32];
   logic        m_halt;
   int          n_checks = 0;
   int          n_errors = 0;
   int          mon_cyc  = 0;

   logic        s_rst = 1'b1, s_ifv = 1'b0, s_pred = 1'b0, s_flush = 1'b0, s_busy = 1'b0, s_wen = 1'b0;
   logic [31:0] s_ir = '0, s_pc = '0, s_wdat = '0;
   logic [4:0]  s_wrd = '0;
   logic [6:0]  ops [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, mon_cyc, act, exp);
      end
   endtask

   function automatic bit known_op(input logic [6:0] op);
      return op inside {OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG};
   endfunction

   function automatic bit reads_rs1(input logic [6:0] op);
      return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op inside {OP_REG, OP_STORE, OP_BRANCH};
   endfunction

   // Immediates assembled arithmetically from the field weights of each format.
   function automatic logic [31:0] spec_imm(input logic [31:0] ir);
      int sir;
      sir = int'($signed(ir));
      case (ir[6:0])
         OP_LOAD, OP_IMM, OP_JALR: return sir >>> 20;
         OP_STORE:  return (sir >>> 25) * 32 + int'(ir[11:7]);
         OP_BRANCH: return (ir[31] ? -4096 : 0) + int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2;
         OP_LUI, OP_AUIPC: return ir & 32'hFFFF_F000;
         OP_JAL:    return (ir[31] ? -(1 << 20) : 0) + int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2;
         default:   return 0;
      endcase
   endfunction

   function automatic logic [31:0] read_reg(input logic [4:0] idx);
      if (idx == 0) return 0;
      if (wb_en && wb_rd == idx) return wb_data;
      return m_rf[idx];
   endfunction

   task automatic model_step();
      logic [6:0] op;
      logic [4:0] r1, r2, rd;
      logic       hz, legal;
      st_t        nx;
      exp_t       e;
      op = IF_ID_IR[6:0];
      rd = IF_ID_IR[11:7];
      r1 = IF_ID_IR[19:15];
      r2 = IF_ID_IR[24:20];
      hz = m_st.valid && m_st.ctrl[5] && m_st.rd != 0 && if_valid &&
           ((reads_rs1(op) && r1 == m_st.rd) || (reads_rs2(op) && r2 == m_st.rd));
      m_halt = !RESET && !flush && (ex_busy || hz);
      legal = known_op(op);
      nx = m_st;
      if (RESET) nx = '0;
      else if (flush || (!ex_busy && (hz || !if_valid))) nx.valid = 1'b0;
      else if (!ex_busy) begin
         nx.valid = 1'b1;
         nx.pc    = IF_ID_PC;
         nx.rs1v  = read_reg(r1);
         nx.rs2v  = read_reg(r2);
         nx.imm   = spec_imm(IF_ID_IR);
         nx.rs1   = r1;
         nx.rs2   = r2;
         nx.rd    = rd;
         nx.op    = op;
         nx.f3    = IF_ID_IR[14:12];
         nx.f7    = IF_ID_IR[31:25];
         nx.ctrl  = {legal && op != OP_STORE && op != OP_BRANCH && rd != 0,
                     op == OP_LOAD, op == OP_STORE, op == OP_BRANCH,
                     op == OP_JAL || op == OP_JALR,
                     op == OP_REG && IF_ID_IR[31:25] == 7'd1, !legal};
         nx.pred  = pred_taken;
      end
      if (RESET) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 0;
      end else if (wb_en && wb_rd != 0) begin
         m_rf[wb_rd] = wb_data;
      end
      m_st     = nx;
      e.halted = m_halt;
      e.st     = nx;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      RESET = s_rst; IF_ID_IR = s_ir; IF_ID_PC = s_pc; if_valid = s_ifv; pred_taken = s_pred;
      flush = s_flush; ex_busy = s_busy; wb_en = s_wen; wb_rd = s_wrd; wb_data = s_wdat;
      model_step();
   endtask

   task automatic issue(input logic [31:0] ir);
      s_ir  = ir;
      s_pc  = s_pc + 32'd1;
      s_ifv = 1'b1;
      tick();
   endtask

   function automatic logic [31:0] rand_ir();
      logic [31:0] ir;
      int          k;
      ir = $urandom;
      k  = $urandom_range(0, 12);
      ir[6:0]   = (k == 12) ? 7'($urandom_range(0, 127)) : ops[k];
      ir[11:7]  = 5'($urandom_range(0, 7));
      ir[19:15] = 5'($urandom_range(0, 7));
      ir[24:20] = 5'($urandom_range(0, 7));
      if (k == 10) ir[31:25] = 7'd1;
      return ir;
   endfunction

   // Monitor: HALTED sampled mid-cycle after inputs settle, ID/EX sampled just after the edge.
   logic h_smp;
   exp_t r;
   initial begin
      forever begin
         @(negedge clk);
         #2 h_smp = HALTED;
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            mon_cyc++;
            check("halted",  32'(h_smp),        32'(r.halted));
            check("valid",   32'(ID_EX_valid),  32'(r.st.valid));
            check("pc",      ID_EX_PC,          r.st.pc);
            check("rs1_val", ID_EX_rs1_val,     r.st.rs1v);
            check("rs2_val", ID_EX_rs2_val,     r.st.rs2v);
            check("imm",     ID_EX_imm,         r.st.imm);
            check("rs1",     32'(ID_EX_rs1),    32'(r.st.rs1));
            check("rs2",     32'(ID_EX_rs2),    32'(r.st.rs2));
            check("rd",      32'(ID_EX_rd),     32'(r.st.rd));
            check("opcode",  32'(ID_EX_opcode), 32'(r.st.op));
            check("funct3",  32'(ID_EX_funct3), 32'(r.st.f3));
            check("funct7",  32'(ID_EX_funct7), 32'(r.st.f7));
            check("ctrl",    32'(ID_EX_ctrl),   32'(r.st.ctrl));
            check("pred",    32'(ID_EX_pred),   32'(r.st.pred));
         end
      end
   end

   initial begin
      ops = '{OP_LOAD, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI,
              OP_AUIPC, OP_JAL, OP_REG, OP_REG, 7'h7F, 7'h00};
      m_st = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;

      s_rst = 1'b1;
      repeat (2) tick();
      s_rst = 1'b0;

      // Every register reads zero straight after reset.
      for (int i = 1; i < 32; i++) issue({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, OP_REG});

      // Seed x1..x7, then same-cycle bypass of x5.
      s_ifv = 1'b0; s_wen = 1'b1;
      for (int i = 1; i < 8; i++) begin
         s_wrd = 5'(i); s_wdat = $urandom; tick();
      end
      s_wrd = 5'd5; s_wdat = 32'hDEAD_BEEF;
      issue(32'h0002_8333);
      s_wen = 1'b0;

      issue(32'hFE00_0CE3);

      // Load-use: the add is held for one bubble, then issues.
      issue(32'h0000_A383);
      s_ir = 32'h0023_8433; tick();
      tick();
      issue(32'h0003_8437);
      issue(32'h0000_A383);
      issue(32'h0003_8437);

      // Load-use hazard and flush together.
      issue(32'h0000_A383);
      s_flush = 1'b1; issue(32'h0023_8433);
      s_flush = 1'b0; issue(32'h0000_0013);

      // MUL held by a busy execute for three cycles.
      issue(32'h0220_84B3);
      s_busy = 1'b1; s_ir = 32'h0023_8433; s_pc = s_pc + 32'd1;
      repeat (3) tick();
      s_busy = 1'b0; tick();

      issue(32'h0000_007F);
      issue(32'h1234_5FFF);

      // Reset while execute is busy.
      issue(32'h0220_84B3);
      s_busy = 1'b1; tick();
      s_rst = 1'b1; tick();
      s_rst = 1'b0; s_busy = 1'b0; issue(32'h0000_0013);

      for (int n = 0; n < 2000; n++) begin
         if (!m_halt) begin
            s_ir   = rand_ir();
            s_pc   = $urandom;
            s_ifv  = ($urandom_range(0, 9) != 0);
            s_pred = 1'($urandom_range(0, 1));
         end
         s_flush = ($urandom_range(0, 19) == 0);
         s_busy  = ($urandom_range(0, 7) == 0);
         s_rst   = ($urandom_range(0, 199) == 0);
         s_wen   = 1'($urandom_range(0, 1));
         s_wrd   = 5'($urandom_range(0, 7));
         s_wdat  = $urandom;
         tick();
      end

      repeat (4) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
